rsa_cmd_dispatcher: RTL and testbench
=====================================

Name: rsa_cmd_dispatcher

Overview:
Parametrised ARM-to-accelerator command front end for the multi-core Montgomery/RSA datapath. It decodes READ/COMPUTE/WRITE commands and moves DATA_W-bit operands in and results out over valid/ready handshakes. It launches any subset of NUM_CORES cores and signals completion through a done/done_read handshake. It sits between the ARM-facing register/DMA port and the core array, replacing the single-core fixed-width wrapper control.

Parameters:
DATA_W, 1024, operand/result width in bits
NUM_CORES, 2, number of exponentiation cores (1..16)
TIMEOUT_CYCLES, 1048576, compute watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
arm_to_fpga_cmd  in  32  command word: [1:0] opcode (0 READ, 1 COMPUTE, 2 WRITE, 3 reserved); [7:4] core index (READ/WRITE); [31:16] core mask (COMPUTE)
arm_to_fpga_cmd_valid  in  1  command strobe
arm_to_fpga_done  out  1  command finished, held until acknowledged
arm_to_fpga_done_read  in  1  done acknowledge
arm_to_fpga_data_valid  in  1  input operand valid
arm_to_fpga_data_ready  out  1  dispatcher accepts operand
arm_to_fpga_data  in  DATA_W  input operand
fpga_to_arm_data_valid  out  1  result valid
fpga_to_arm_data_ready  in  1  ARM accepts result
fpga_to_arm_data  out  DATA_W  result
core_din  out  DATA_W  operand broadcast to cores
core_load  out  NUM_CORES  one-cycle load pulse per core
core_start  out  NUM_CORES  one-cycle start pulse per core
core_done  in  NUM_CORES  per-core completion pulse or level
core_result  in  NUM_CORES*DATA_W  concatenated results; core i occupies bits [i*DATA_W +: DATA_W]
leds  out  4  [0] idle, [1] computing, [2] done pending, [3] error

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All outputs are 0 except leds=4'b0001. The done latches, error flag and data registers are cleared. Any in-flight transfer is discarded.
- States: IDLE, RX, START, WAIT, TX, DONE.
- IDLE: on cmd_valid, the command is registered and error is cleared.
  - READ with index<NUM_CORES: go to RX.
  - WRITE with index<NUM_CORES: go to TX, capturing core_result[index] into fpga_to_arm_data on the same edge.
  - COMPUTE with mask&((1<<NUM_CORES)-1) != 0: go to START.
  - Any other case (opcode 3, bad index, empty effective mask): set error and go to DONE.
- cmd_valid is ignored outside IDLE, including a simultaneous cmd_valid and done_read in DONE.
- RX: data_ready=1. A transfer occurs on the edge where valid&&ready. That edge registers core_din, pulses core_load[index] for exactly the next cycle, drops ready, and goes to DONE. Input valid may be asserted before ready.
- TX: fpga_to_arm_data_valid=1 and data is stable. On the edge where valid&&ready, valid drops and the FSM goes to DONE.
- START: core_start=effective mask for one cycle. Per-core done latches are cleared. Go to WAIT.
- WAIT: each core_done[i] sets latch i. A core_done arriving in the START cycle is counted. When every masked latch is set, go to DONE. Latency from START is max core latency + 1.
- DONE: arm_to_fpga_done=1. On done_read=1, go to IDLE the next cycle. Error remains visible on leds[3] until the next accepted command.
- core_load and core_start are never both non-zero. Pulses to unselected cores are 0.

Optional Feature:
- Macro RSA_CMD_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT. When the count reaches TIMEOUT_CYCLES with latches still incomplete, the FSM sets error and goes to DONE. Late core_done pulses after that point are ignored.
- Not defined: no counter, and WAIT exits only on completion.

Test Plan:
- Reset mid-RX (reset pulsed while data_ready=1) -> all outputs 0 and leds=0001 within the same cycle; the following READ works normally.
- READ idx 1, operand 0x0123456789abcdef<<768, valid asserted 3 cycles before ready -> exactly one core_load=2'b10 pulse, core_din equals the operand, done=1 until done_read, then idle.
- COMPUTE mask 0x0003, core_done[0] after 5 cycles and core_done[1] after 9 -> core_start=2'b11 for one cycle; done rises 1 cycle after core_done[1], not after core_done[0].
- WRITE idx 0 with core_result[0]=0xDEADBEEF, ARM ready delayed 4 cycles -> valid held 4 cycles, data=0xDEADBEEF throughout, single transfer, then done.
- Opcode 3, then READ idx 5 with NUM_CORES=2, then COMPUTE mask 0x0004 -> each gives done with leds[3]=1 and no core_load/core_start pulses; the next valid READ clears leds[3].
- With RSA_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=64: COMPUTE mask 0x0001 and core_done never asserted -> done with error exactly 64 cycles after WAIT entry.

Source files
------------

// File: rtl/rsa_cmd_dispatcher_if.sv
// ---------------------------------------------------------------------------
// rsa_cmd_dispatcher_if
// ARM-facing command / operand / result bus of the RSA command dispatcher.
//   arm_to_fpga_cmd[31:0], arm_to_fpga_cmd_valid : command word and strobe
//   arm_to_fpga_done, arm_to_fpga_done_read      : completion flag and ack
//   arm_to_fpga_data*                            : operand stream into FPGA
//   fpga_to_arm_data*                            : result stream to ARM
// Modports: master = ARM side, slave = dispatcher side.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface rsa_cmd_dispatcher_if #(
   parameter int DATA_W = 1024
);
   logic [31:0]       arm_to_fpga_cmd;
   logic              arm_to_fpga_cmd_valid;
   logic              arm_to_fpga_done;
   logic              arm_to_fpga_done_read;
   logic              arm_to_fpga_data_valid;
   logic              arm_to_fpga_data_ready;
   logic [DATA_W-1:0] arm_to_fpga_data;
   logic              fpga_to_arm_data_valid;
   logic              fpga_to_arm_data_ready;
   logic [DATA_W-1:0] fpga_to_arm_data;

   modport master (
      output arm_to_fpga_cmd, arm_to_fpga_cmd_valid, arm_to_fpga_done_read,
             arm_to_fpga_data_valid, arm_to_fpga_data, fpga_to_arm_data_ready,
      input  arm_to_fpga_done, arm_to_fpga_data_ready,
             fpga_to_arm_data_valid, fpga_to_arm_data
   );

   modport slave (
      input  arm_to_fpga_cmd, arm_to_fpga_cmd_valid, arm_to_fpga_done_read,
             arm_to_fpga_data_valid, arm_to_fpga_data, fpga_to_arm_data_ready,
      output arm_to_fpga_done, arm_to_fpga_data_ready,
             fpga_to_arm_data_valid, fpga_to_arm_data
   );
endinterface

// File: rtl/rsa_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// rsa_cmd_dispatcher
// Command front end between the ARM register/DMA port and an array of
// NUM_CORES Montgomery exponentiation cores.
//   READ    : accept one DATA_W operand, broadcast on core_din, pulse
//             core_load[index].
//   COMPUTE : pulse core_start for the cores in the mask, wait until each of
//             them has reported core_done.
//   WRITE   : return core_result[index] on the fpga_to_arm stream.
// Every command (including rejected ones) ends in DONE, which holds
// arm_to_fpga_done until arm_to_fpga_done_read.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   arm          : ARM bus (rsa_cmd_dispatcher_if.slave)
//   core_din     : operand broadcast to all cores
//   core_load    : per-core one-cycle load pulse
//   core_start   : per-core one-cycle start pulse
//   core_done    : per-core completion (pulse or level)
//   core_result  : concatenated core results, core i at [i*DATA_W +: DATA_W]
//   leds         : [0] idle, [1] computing, [2] done pending, [3] error
// Optional feature: define RSA_CMD_TIMEOUT_EN to add a compute watchdog of
// TIMEOUT_CYCLES cycles in WAIT that ends the command with error set.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module rsa_cmd_dispatcher #(
   parameter int DATA_W         = 1024,
   parameter int NUM_CORES      = 2,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                          clk,
   input  logic                          reset,
   rsa_cmd_dispatcher_if.slave           arm,
   output logic [DATA_W-1:0]             core_din,
   output logic [NUM_CORES-1:0]          core_load,
   output logic [NUM_CORES-1:0]          core_start,
   input  logic [NUM_CORES-1:0]          core_done,
   input  logic [NUM_CORES*DATA_W-1:0]   core_result,
   output logic [3:0]                    leds
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RX,
      ST_START,
      ST_WAIT,
      ST_TX,
      ST_DONE
   } state_t;

   state_t                state_reg,   state_next;
   logic                  error_reg,   error_next;
   logic [NUM_CORES-1:0]  sel_reg,     sel_next;     // one-hot target core
   logic [NUM_CORES-1:0]  mask_reg,    mask_next;    // effective compute mask
   logic [NUM_CORES-1:0]  latch_reg,   latch_next;   // per-core done latches
   logic [NUM_CORES-1:0]  load_reg,    load_next;
   logic [DATA_W-1:0]     din_reg,     din_next;
   logic [DATA_W-1:0]     tx_data_reg, tx_data_next;

`ifdef RSA_CMD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0]      wait_cnt_reg, wait_cnt_next;
`else
   logic [31:0]           unused_timeout;
   assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

   // Command field decode
   logic [1:0]            cmd_op;
   logic [3:0]            cmd_idx;
   logic [NUM_CORES-1:0]  cmd_idx_hit;
   logic [NUM_CORES-1:0]  cmd_mask;
   logic [DATA_W-1:0]     result_arr [NUM_CORES];
   logic [DATA_W-1:0]     cmd_result;
   logic                  unused_cmd_bits;

   assign cmd_op   = arm.arm_to_fpga_cmd[1:0];
   assign cmd_idx  = arm.arm_to_fpga_cmd[7:4];
   // Mask bits above NUM_CORES are dropped here, so an out-of-range mask
   // degenerates into an empty effective mask.
   assign cmd_mask = arm.arm_to_fpga_cmd[16 +: NUM_CORES];
   assign unused_cmd_bits = ^arm.arm_to_fpga_cmd;

   generate
      for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
         assign result_arr[gi]  = core_result[gi*DATA_W +: DATA_W];
         assign cmd_idx_hit[gi] = (cmd_idx == 4'(gi));
      end
   endgenerate

   // An index >= NUM_CORES hits no core, which is how a bad index is seen.
   always_comb begin
      cmd_result = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (cmd_idx_hit[i]) begin
            cmd_result = result_arr[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         error_reg    <= 1'b0;
         sel_reg      <= '0;
         mask_reg     <= '0;
         latch_reg    <= '0;
         load_reg     <= '0;
         din_reg      <= '0;
         tx_data_reg  <= '0;
`ifdef RSA_CMD_TIMEOUT_EN
         wait_cnt_reg <= '0;
`endif
      end else begin
         state_reg    <= state_next;
         error_reg    <= error_next;
         sel_reg      <= sel_next;
         mask_reg     <= mask_next;
         latch_reg    <= latch_next;
         load_reg     <= load_next;
         din_reg      <= din_next;
         tx_data_reg  <= tx_data_next;
`ifdef RSA_CMD_TIMEOUT_EN
         wait_cnt_reg <= wait_cnt_next;
`endif
      end
   end

   always_comb begin
      state_next    = state_reg;
      error_next    = error_reg;
      sel_next      = sel_reg;
      mask_next     = mask_reg;
      latch_next    = latch_reg;
      load_next     = '0;
      din_next      = din_reg;
      tx_data_next  = tx_data_reg;
`ifdef RSA_CMD_TIMEOUT_EN
      wait_cnt_next = wait_cnt_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (arm.arm_to_fpga_cmd_valid) begin
               error_next = 1'b0;
               sel_next   = cmd_idx_hit;
               case (cmd_op)
                  2'd0: begin
                     if (|cmd_idx_hit) state_next = ST_RX;
                     else begin
                        error_next = 1'b1;
                        state_next = ST_DONE;
                     end
                  end
                  2'd1: begin
                     mask_next = cmd_mask;
                     if (|cmd_mask) state_next = ST_START;
                     else begin
                        error_next = 1'b1;
                        state_next = ST_DONE;
                     end
                  end
                  2'd2: begin
                     if (|cmd_idx_hit) begin
                        tx_data_next = cmd_result;
                        state_next   = ST_TX;
                     end else begin
                        error_next = 1'b1;
                        state_next = ST_DONE;
                     end
                  end
                  default: begin
                     error_next = 1'b1;
                     state_next = ST_DONE;
                  end
               endcase
            end
         end
         ST_RX: begin
            if (arm.arm_to_fpga_data_valid) begin
               din_next   = arm.arm_to_fpga_data;
               load_next  = sel_reg;
               state_next = ST_DONE;
            end
         end
         ST_START: begin
            // Latches restart here, but a done seen in this cycle still counts.
            latch_next = core_done & mask_reg;
`ifdef RSA_CMD_TIMEOUT_EN
            wait_cnt_next = '0;
`endif
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            latch_next = latch_reg | (core_done & mask_reg);
            if ((latch_next & mask_reg) == mask_reg) begin
               state_next = ST_DONE;
            end
`ifdef RSA_CMD_TIMEOUT_EN
            // Count 0 is the first WAIT cycle, so expiry lands exactly
            // TIMEOUT_CYCLES cycles after WAIT entry.
            else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               error_next = 1'b1;
               state_next = ST_DONE;
            end else begin
               wait_cnt_next = wait_cnt_reg + CNT_W'(1);
            end
`endif
         end
         ST_TX: begin
            if (arm.fpga_to_arm_data_ready) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (arm.arm_to_fpga_done_read) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign arm.arm_to_fpga_done       = (state_reg == ST_DONE);
   assign arm.arm_to_fpga_data_ready = (state_reg == ST_RX);
   assign arm.fpga_to_arm_data_valid = (state_reg == ST_TX);
   assign arm.fpga_to_arm_data       = tx_data_reg;

   assign core_din   = din_reg;
   assign core_load  = load_reg;
   assign core_start = (state_reg == ST_START) ? mask_reg : '0;

   assign leds = {error_reg,
                  state_reg == ST_DONE,
                  (state_reg == ST_START) || (state_reg == ST_WAIT),
                  state_reg == ST_IDLE};

endmodule

// File: tb/tb_rsa_cmd_dispatcher.sv
`timescale 1ns/1ps

module tb_rsa_cmd_dispatcher;
   localparam int DATA_W         = 1024;
   localparam int NUM_CORES      = 2;
   localparam int TIMEOUT_CYCLES = 1048576;

   localparam int K_LOAD  = 0;
   localparam int K_START = 1;
   localparam int K_TX    = 2;
   localparam int K_DONE  = 3;

   typedef struct {
      int                   kind;
      logic [NUM_CORES-1:0] mask;
      logic [DATA_W-1:0]    data;
      bit                   err;
      int                   lat;
   } exp_t;

   exp_t sb[$];

   logic                        clk = 1'b0;
   logic                        reset = 1'b1;
   logic [DATA_W-1:0]           core_din;
   logic [NUM_CORES-1:0]        core_load;
   logic [NUM_CORES-1:0]        core_start;
   logic [NUM_CORES-1:0]        core_done;
   logic [NUM_CORES*DATA_W-1:0] core_result;
   logic [3:0]                  leds;
   logic [DATA_W-1:0]           res_model [NUM_CORES];
   int                          lat_cfg [NUM_CORES];

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rsa_cmd_dispatcher_if #(.DATA_W(DATA_W)) arm_if ();

   generate
      for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_res
         assign core_result[gi*DATA_W +: DATA_W] = res_model[gi];
      end
   endgenerate

   rsa_cmd_dispatcher #(
      .DATA_W(DATA_W), .NUM_CORES(NUM_CORES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .arm(arm_if),
      .core_din(core_din), .core_load(core_load), .core_start(core_start),
      .core_done(core_done), .core_result(core_result), .leds(leds)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_data(input string name, input logic [DATA_W-1:0] act,
                           input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         int w = 0;
         n_fail++;
         for (int i = DATA_W/64 - 1; i >= 0; i--)
            if (act[i*64 +: 64] !== exp[i*64 +: 64]) w = i;
         $display("FAIL %s: word %0d got %h expected %h (cycle %0d)",
                  name, w, act[w*64 +: 64], exp[w*64 +: 64], cyc);
      end
   endtask

   task automatic unexpected(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got event with no matching expectation (cycle %0d)", name, cyc);
   endtask

   function automatic logic [DATA_W-1:0] rand_wide();
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic push_exp(input int kind, input logic [NUM_CORES-1:0] mask,
                           input logic [DATA_W-1:0] data, input bit err, input int lat);
      exp_t e;
      e.kind = kind; e.mask = mask; e.data = data; e.err = err; e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [31:0] c);
      arm_if.arm_to_fpga_cmd       = c;
      arm_if.arm_to_fpga_cmd_valid = 1'b1;
      tick();
      arm_if.arm_to_fpga_cmd_valid = 1'b0;
      arm_if.arm_to_fpga_cmd       = $urandom();
   endtask

   // Waits (bounded) for done, then acknowledges it; a reserved-opcode
   // command strobed alongside must be ignored.
   task automatic ack_done(input int r);
      int n = 0;
      while (!arm_if.arm_to_fpga_done && n < 2000) begin
         tick();
         n++;
      end
      chk("done_seen", 64'(arm_if.arm_to_fpga_done), 64'd1);
      repeat (r) tick();
      arm_if.arm_to_fpga_done_read = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
         arm_if.arm_to_fpga_cmd       = {$urandom_range(0, 65535), 14'd0, 2'd3};
         arm_if.arm_to_fpga_cmd_valid = 1'b1;
      end
      tick();
      arm_if.arm_to_fpga_done_read = 1'b0;
      arm_if.arm_to_fpga_cmd_valid = 1'b0;
   endtask

   task automatic do_read(input int idx, input logic [DATA_W-1:0] data,
                          input bit early, input int dly);
      logic [31:0] c = $urandom();
      bit ok = (idx < NUM_CORES);
      c[1:0] = 2'd0;
      c[7:4] = 4'(idx);
      if (ok) begin
         push_exp(K_LOAD, NUM_CORES'(1) << idx, data, 1'b0, 0);
         push_exp(K_DONE, '0, '0, 1'b0, 0);
      end else begin
         push_exp(K_DONE, '0, '0, 1'b1, 0);
      end
      arm_if.arm_to_fpga_data = data;
      if (early) begin
         arm_if.arm_to_fpga_data_valid = 1'b1;
         repeat (dly) tick();
      end
      send_cmd(c);
      if (ok) begin
         if (early) begin
            tick();
         end else begin
            repeat (dly) tick();
            arm_if.arm_to_fpga_data_valid = 1'b1;
            tick();
         end
      end
      arm_if.arm_to_fpga_data_valid = 1'b0;
      arm_if.arm_to_fpga_data       = rand_wide();
      ack_done($urandom_range(0, 3));
   endtask

   task automatic do_write(input int idx, input logic [DATA_W-1:0] val, input int d);
      logic [31:0] c = $urandom();
      bit ok = (idx < NUM_CORES);
      c[1:0] = 2'd2;
      c[7:4] = 4'(idx);
      if (ok) begin
         res_model[idx] = val;
         push_exp(K_TX, '0, val, 1'b0, d + 1);
         push_exp(K_DONE, '0, '0, 1'b0, 0);
      end else begin
         push_exp(K_DONE, '0, '0, 1'b1, 0);
      end
      send_cmd(c);
      // Result must have been captured at acceptance, not followed live.
      for (int i = 0; i < NUM_CORES; i++) res_model[i] = rand_wide();
      if (ok) begin
         repeat (d) tick();
         arm_if.fpga_to_arm_data_ready = 1'b1;
         tick();
         arm_if.fpga_to_arm_data_ready = 1'b0;
      end
      ack_done($urandom_range(0, 3));
   endtask

   // Core i reports done lat_cfg[i] cycles after the START cycle.
   task automatic do_compute(input logic [15:0] mask16);
      logic [31:0]          c = $urandom();
      logic [NUM_CORES-1:0] eff = mask16[NUM_CORES-1:0];
      logic [NUM_CORES-1:0] cd;
      int                   maxl = 0;
      c[1:0]   = 2'd1;
      c[31:16] = mask16;
      for (int i = 0; i < NUM_CORES; i++)
         if (eff[i] && lat_cfg[i] > maxl) maxl = lat_cfg[i];
      if (eff == '0) begin
         push_exp(K_DONE, '0, '0, 1'b1, 0);
         send_cmd(c);
      end else begin
         push_exp(K_START, eff, '0, 1'b0, 0);
         push_exp(K_DONE, '0, '0, 1'b0, maxl + 1);
         send_cmd(c);
         for (int j = 0; j <= maxl; j++) begin
            cd = '0;
            for (int i = 0; i < NUM_CORES; i++) begin
               if (eff[i]) cd[i] = (lat_cfg[i] == j);
               else        cd[i] = 1'($urandom_range(0, 1));
            end
            core_done = cd;
            tick();
         end
         core_done = '0;
      end
      ack_done($urandom_range(0, 3));
   endtask

   task automatic do_op3();
      logic [31:0] c = $urandom();
      c[1:0] = 2'd3;
      push_exp(K_DONE, '0, '0, 1'b1, 0);
      send_cmd(c);
      ack_done($urandom_range(0, 3));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_data_ready"}, 64'(arm_if.arm_to_fpga_data_ready), 64'd0);
      chk({tag, "_tx_valid"},   64'(arm_if.fpga_to_arm_data_valid), 64'd0);
      chk({tag, "_done"},       64'(arm_if.arm_to_fpga_done), 64'd0);
      chk({tag, "_load"},       64'(core_load), 64'd0);
      chk({tag, "_start"},      64'(core_start), 64'd0);
      chk({tag, "_leds"},       64'(leds), 64'h1);
      chk_data({tag, "_core_din"}, core_din, '0);
      chk_data({tag, "_tx_data"},  arm_if.fpga_to_arm_data, '0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT shows an observable event.
   initial begin
      exp_t e;
      bit   done_q = 1'b0;
      bit   dr_q = 1'b0;
      bit   last_err = 1'b0;
      int   start_cyc = 0;
      int   tx_cnt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            done_q = 1'b0; dr_q = 1'b0; tx_cnt = 0; last_err = 1'b0;
            continue;
         end
         if (core_load != '0) begin
            if (sb.size() == 0 || sb[0].kind != K_LOAD) unexpected("core_load");
            else begin
               e = sb.pop_front();
               chk("load_mask", 64'(core_load), 64'(e.mask));
               chk_data("core_din", core_din, e.data);
               chk("load_start_exclusive", 64'(core_start), 64'd0);
            end
         end
         if (core_start != '0) begin
            if (sb.size() == 0 || sb[0].kind != K_START) unexpected("core_start");
            else begin
               e = sb.pop_front();
               chk("start_mask", 64'(core_start), 64'(e.mask));
               start_cyc = cyc;
            end
         end
         if (arm_if.fpga_to_arm_data_valid) begin
            tx_cnt++;
            if (sb.size() == 0 || sb[0].kind != K_TX) begin
               unexpected("tx_valid");
               tx_cnt = 0;
            end else begin
               chk_data("tx_data", arm_if.fpga_to_arm_data, sb[0].data);
               if (arm_if.fpga_to_arm_data_ready) begin
                  e = sb.pop_front();
                  chk("tx_valid_cycles", 64'(tx_cnt), 64'(e.lat));
                  tx_cnt = 0;
               end
            end
         end
         if (arm_if.arm_to_fpga_done && !done_q) begin
            if (sb.size() == 0 || sb[0].kind != K_DONE) unexpected("done_rise");
            else begin
               e = sb.pop_front();
               chk("done_error_led", 64'(leds[3]), 64'(e.err));
               chk("done_pending_led", 64'(leds[2]), 64'd1);
               if (e.lat > 0) chk("compute_latency", 64'(cyc - start_cyc), 64'(e.lat));
               last_err = e.err;
            end
         end
         if (!arm_if.arm_to_fpga_done && done_q) begin
            chk("done_held_until_ack", 64'(dr_q), 64'd1);
            chk("idle_leds", 64'(leds), 64'({last_err, 3'b001}));
         end
         done_q = arm_if.arm_to_fpga_done;
         dr_q   = arm_if.arm_to_fpga_done_read;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] op;
      arm_if.arm_to_fpga_cmd        = '0;
      arm_if.arm_to_fpga_cmd_valid  = 1'b0;
      arm_if.arm_to_fpga_done_read  = 1'b0;
      arm_if.arm_to_fpga_data_valid = 1'b0;
      arm_if.arm_to_fpga_data       = '0;
      arm_if.fpga_to_arm_data_ready = 1'b0;
      core_done = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         res_model[i] = rand_wide();
         lat_cfg[i]   = 1;
      end

      tick();
      tick();
      chk_reset_outputs("reset");
      reset = 1'b0;
      tick();

      op = DATA_W'(64'h0123456789abcdef) << 768;
      do_read(1, op, 1'b1, 3);
      do_write(0, DATA_W'(32'hDEADBEEF), 4);

      // Reset while waiting for an operand.
      send_cmd(32'h0000_0000);
      tick();
      chk("rx_ready_before_reset", 64'(arm_if.arm_to_fpga_data_ready), 64'd1);
      #1 reset = 1'b1;
      #1 chk_reset_outputs("mid_rx_reset");
      sb.delete();
      #1 reset = 1'b0;
      tick();
      do_read(0, rand_wide(), 1'b0, 2);

      lat_cfg[0] = 5;
      lat_cfg[1] = 9;
      do_compute(16'h0003);

      do_op3();
      do_read(5, rand_wide(), 1'b0, 0);
      do_compute(16'h0004);
      do_read(1, rand_wide(), 1'b0, 1);

      for (int t = 0; t < 40; t++) begin
         int op_sel = $urandom_range(0, 3);
         case (op_sel)
            0: do_read($urandom_range(0, 3), rand_wide(), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 4));
            1: begin
               logic [15:0] m = 16'($urandom());
               if ($urandom_range(0, 4) == 0) m[NUM_CORES-1:0] = '0;
               for (int i = 0; i < NUM_CORES; i++) lat_cfg[i] = $urandom_range(1, 12);
               do_compute(m);
            end
            2: do_write($urandom_range(0, 3), rand_wide(), $urandom_range(0, 5));
            default: do_op3();
         endcase
      end

      repeat (5) tick();
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
